// File: rtl/jtcop_pkg.sv
// jtcop_pkg: shared types and constants for the main-CPU to MCU mailbox
// Holds the mailbox FSM state encoding, CPU register offsets (cpu_addr[2:1])
// and the bit positions of the status word.
package jtcop_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } mbox_state_e;
  localparam logic [1:0] MBOX_DATA = 2'd0;
  localparam logic [1:0] MBOX_STAT = 2'd1;
  localparam logic [1:0] MBOX_SEL  = 2'd2;
  localparam logic [1:0] MBOX_CLR  = 2'd3;
  localparam int STAT_BUSY   = 15;
  localparam int STAT_RVALID = 14;
  localparam int STAT_OVR    = 13;
  localparam int STAT_TOUT   = 12;
  // dsn bits are active-low byte enables: {UDSWn, LDSWn}
  function automatic logic [15:0] lane_merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                             input logic [1:0] dsn);
    return {dsn[1] ? old_v[15:8] : new_v[15:8], dsn[0] ? old_v[7:0] : new_v[7:0]};
  endfunction
endpackage

// File: rtl/jtcop_mbox_edge.sv
// jtcop_mbox_edge: rising-edge detector against the previous clk sample
// Ports: clk, rst (async, active high), sig_i level input, rise_o edge pulse.
// REG=0 gives a combinational pulse in the first high cycle; REG=1 delays
// the pulse by one register stage.
module jtcop_mbox_edge #(
  parameter bit REG = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);
  logic prev_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) prev_q <= 1'b0;
    else     prev_q <= sig_i;
  generate
    if (REG) begin : g_reg
      logic rise_q;
      always_ff @(posedge clk or posedge rst)
        if (rst) rise_q <= 1'b0;
        else     rise_q <= sig_i & ~prev_q;
      assign rise_o = rise_q;
    end else begin : g_comb
      assign rise_o = sig_i & ~prev_q;
    end
  endgenerate
endmodule

// File: rtl/jtcop_mcu_mbox.sv
// jtcop_mcu_mbox: main-CPU side command/reply mailbox toward the i8751 MCU
// Ports: clk/rst (async, active high); CPU side cs, addr, cpu_rnw, dsn,
// cpu_dout, cpu_din; MCU side mcu_din (command), mcu_dout/mcu_ack (reply),
// sec (selects, [0] = attention strobe), busy.
// Optional MCU_TOUT_EN adds a reply timeout of TOUT cycles in WAIT.
module jtcop_mcu_mbox
  import jtcop_pkg::*;
#(
  parameter int          STB_LEN = 4,
  parameter logic [15:0] TOUT    = 16'd4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic [1:0]  addr,
  input  logic        cpu_rnw,
  input  logic [1:0]  dsn,
  input  logic [15:0] cpu_dout,
  output logic [15:0] cpu_din,
  output logic [15:0] mcu_din,
  input  logic [15:0] mcu_dout,
  input  logic        mcu_ack,
  output logic [5:0]  sec,
  output logic        busy
);
  logic cs_rise, ack_rise, wr, rd0, tout;
  mbox_state_e st_q, st_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] din_q, din_d, rep_q, rep_d, stat;
  logic        rv_q, rv_d, ovr_q, ovr_d;
  logic [2:0]  sel_q, sel_d;
  jtcop_mbox_edge #(.REG(1'b0)) u_cs_edge (.clk(clk), .rst(rst), .sig_i(cs), .rise_o(cs_rise));
  // Extra register stage gives the 2-cycle ack-to-status latency
  jtcop_mbox_edge #(.REG(1'b1)) u_ack_edge (.clk(clk), .rst(rst), .sig_i(mcu_ack), .rise_o(ack_rise));
  assign wr  = cs & ~cpu_rnw & cs_rise;
  assign rd0 = cs & cpu_rnw & cs_rise & (addr == MBOX_DATA);
`ifdef MCU_TOUT_EN
  logic [15:0] tcnt_q, tcnt_d;
  logic        tout_q, tout_d;
  assign tout = tout_q;
`else
  logic unused_tout;
  assign unused_tout = ^TOUT;
  assign tout = 1'b0;
`endif
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    din_d = din_q;
    rep_d = rep_q;
    rv_d  = rv_q;
    ovr_d = ovr_q;
    sel_d = sel_q;
`ifdef MCU_TOUT_EN
    tcnt_d = tcnt_q;
    tout_d = tout_q;
`endif
    if (wr && addr == MBOX_SEL && !dsn[0]) sel_d = cpu_dout[2:0];
    if (wr && addr == MBOX_CLR) begin
      ovr_d = 1'b0;
      rv_d  = 1'b0;
`ifdef MCU_TOUT_EN
      tout_d = 1'b0;
`endif
    end
    if (rd0) rv_d = 1'b0;
    // DONE counts as busy for a new command, so a write there is an overrun
    if (wr && addr == MBOX_DATA && st_q != ST_IDLE) ovr_d = 1'b1;
    case (st_q)
      ST_IDLE:
        if (wr && addr == MBOX_DATA) begin
          din_d = lane_merge(din_q, cpu_dout, dsn);
          cnt_d = 4'(STB_LEN);
          st_d  = ST_STROBE;
        end
      ST_STROBE:
        if (cnt_q == 4'd1) begin
          st_d = ST_WAIT;
`ifdef MCU_TOUT_EN
          tcnt_d = 16'd0;
`endif
        end else cnt_d = cnt_q - 4'd1;
      ST_WAIT:
        if (ack_rise) begin
          rep_d = mcu_dout;
          rv_d  = 1'b1;
          st_d  = ST_DONE;
        end
`ifdef MCU_TOUT_EN
        else if (tcnt_q == TOUT) begin
          rep_d  = 16'hFFFF;
          rv_d   = 1'b1;
          tout_d = 1'b1;
          st_d   = ST_DONE;
        end else tcnt_d = tcnt_q + 16'd1;
`endif
      ST_DONE: st_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q  <= ST_IDLE;
      cnt_q <= '0;
      din_q <= '0;
      rep_q <= '0;
      rv_q  <= 1'b0;
      ovr_q <= 1'b0;
      sel_q <= '0;
`ifdef MCU_TOUT_EN
      tcnt_q <= '0;
      tout_q <= 1'b0;
`endif
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      din_q <= din_d;
      rep_q <= rep_d;
      rv_q  <= rv_d;
      ovr_q <= ovr_d;
      sel_q <= sel_d;
`ifdef MCU_TOUT_EN
      tcnt_q <= tcnt_d;
      tout_q <= tout_d;
`endif
    end
  assign busy    = (st_q == ST_STROBE) || (st_q == ST_WAIT);
  assign sec     = {sel_q, 2'b00, st_q == ST_STROBE};
  assign mcu_din = din_q;
  always_comb begin
    stat = '0;
    stat[STAT_BUSY]   = busy;
    stat[STAT_RVALID] = rv_q;
    stat[STAT_OVR]    = ovr_q;
    stat[STAT_TOUT]   = tout;
  end
  // rep_d lets a read in the capture cycle already see the new reply
  assign cpu_din = addr == MBOX_DATA ? rep_d : addr == MBOX_STAT ? stat : 16'd0;
endmodule
